pc_unit: RTL and testbench



---
 rtl/pc_unit_pkg.sv | 20 ++
 rtl/pc_unit_if.sv | 26 ++
 rtl/pc_range_chk.sv | 29 ++
 rtl/pc_unit.sv | 73 +++++++
 tb/tb_pc_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Shared constants and types for the fetch-stage program counter.
// Address defaults match the single-cycle core's memory map.
`ifndef PC_default
`define PC_default 32'h0000_3000
`endif

package pc_unit_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT   = `PC_default;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEFAULT    = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT   = 4096;

    // The state is exactly the pending-redirect flag.
    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_BUSY = 1'b1
    } pend_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/data bundle between the hazard/branch/CP0 logic and the PC unit.
// Inputs are level signals sampled on the rising edge; there is no back-pressure.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;
    logic             exc_req;
    logic             eret_req;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             pend_valid;
    logic             fetch_adel;

    modport master (
        output stall, redir_valid, redir_target, exc_req, eret_req, epc,
        input  pc, pc_plus4, pend_valid, fetch_adel
    );

    modport slave (
        input  stall, redir_valid, redir_target, exc_req, eret_req, epc,
        output pc, pc_plus4, pend_valid, fetch_adel
    );
endinterface

// File: rtl/pc_range_chk.sv
// Flags a fetch address that is misaligned or outside instruction memory.
// Compares in WIDTH+1 bits so a memory ending at the top of the space cannot overflow.
module pc_range_chk #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] IM_BASE  = WIDTH'(32'h0000_3000),
    parameter int               IM_WORDS = 4096
) (
    input  logic [WIDTH-1:0] pc,
    output logic             fetch_adel
);

    localparam logic [WIDTH:0] IM_LO   = {1'b0, IM_BASE};
    localparam logic [WIDTH:0] IM_SPAN = (WIDTH+1)'(64'(IM_WORDS) * 64'd4);
    localparam logic [WIDTH:0] IM_HI   = IM_LO + IM_SPAN;

    logic [WIDTH:0] pc_ext;
    logic           misaligned;
    logic           below;
    logic           above;

    always_comb begin
        pc_ext     = {1'b0, pc};
        misaligned = (pc[1:0] != 2'b00);
        below      = (pc_ext < IM_LO);
        above      = (pc_ext >= IM_HI);
        fetch_adel = misaligned | below | above;
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC: stall hold, redirect, exception entry, eret return and
// a one-deep buffer for a redirect that lands while the F stage is frozen.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_DEFAULT),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT),
    parameter logic [WIDTH-1:0] IM_BASE    = WIDTH'(IM_BASE_DEFAULT),
    parameter int               IM_WORDS   = IM_WORDS_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    pend_state_e      state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            state_q       <= PEND_IDLE;
        end else begin
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            state_q       <= state_d;
        end
    end

    // Priority: exception, eret, stall (buffer redirect), live redirect, buffered redirect, +4.
    always_comb begin
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        state_d       = state_q;
        if (bus.exc_req) begin
            pc_d    = EXC_VECTOR;
            state_d = PEND_IDLE;
        end else if (bus.eret_req) begin
            pc_d    = bus.epc;
            state_d = PEND_IDLE;
        end else if (bus.stall) begin
            if (bus.redir_valid) begin
                pend_target_d = bus.redir_target;
                state_d       = PEND_BUSY;
            end
        end else if (bus.redir_valid) begin
            pc_d    = bus.redir_target;
            state_d = PEND_IDLE;
        end else if (state_q == PEND_BUSY) begin
            pc_d    = pend_target_q;
            state_d = PEND_IDLE;
        end else begin
            pc_d = pc_q + WIDTH'(4);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus4   = pc_q + WIDTH'(4);
    assign bus.pend_valid = (state_q == PEND_BUSY);

    pc_range_chk #(
        .WIDTH   (WIDTH),
        .IM_BASE (IM_BASE),
        .IM_WORDS(IM_WORDS)
    ) u_range_chk (
        .pc        (pc_q),
        .fetch_adel(bus.fetch_adel)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by random stimulus,
// all compared against an address-level reference model.
module tb_pc_unit;

    localparam logic [31:0] M_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] M_EXC_VEC  = 32'h0000_4180;
    localparam longint      M_IM_LO    = 64'h3000;
    localparam longint      M_IM_HI    = 64'h3000 + 4 * 4096;

    logic clk;
    logic reset;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_adel(input logic [31:0] a);
        longint v;
        v = longint'(a);
        return (v % 4 != 0) || (v < M_IM_LO) || (v >= M_IM_HI);
    endfunction

    // Spec rules applied to the architectural values of one edge.
    task automatic model_edge(input logic rst, input logic st, input logic rv,
                              input logic [31:0] rt, input logic ex,
                              input logic er, input logic [31:0] ep);
        if (rst) begin
            m_pc = M_RESET_PC; m_pend = 1'b0; m_tgt = 32'h0;
        end else if (ex) begin
            m_pc = M_EXC_VEC; m_pend = 1'b0;
        end else if (er) begin
            m_pc = ep; m_pend = 1'b0;
        end else if (st) begin
            if (rv) begin
                m_tgt = rt; m_pend = 1'b1;
            end
        end else if (rv) begin
            m_pc = rt; m_pend = 1'b0;
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 1'b0;
        end else begin
            m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        end
        exp_q.push_back(m_pc);
    endtask

    task automatic cyc(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rt, input logic ex,
                       input logic er, input logic [31:0] ep);
        logic [31:0] e;
        reset            = rst;
        bus.stall        = st;
        bus.redir_valid  = rv;
        bus.redir_target = rt;
        bus.exc_req      = ex;
        bus.eret_req     = er;
        bus.epc          = ep;
        @(posedge clk);
        model_edge(rst, st, rv, rt, ex, er, ep);
        @(negedge clk);
        e = exp_q.pop_front();
        check_eq("pc", bus.pc, e);
        check_eq("pc_plus4", bus.pc_plus4, e + 32'd4);
        check_eq("pend_valid", {31'b0, bus.pend_valid}, {31'b0, m_pend});
        check_eq("fetch_adel", {31'b0, bus.fetch_adel}, {31'b0, model_adel(e)});
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: return 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            7: return 32'h3000 + 32'($urandom_range(0, 16383));
            8: return $urandom();
            default: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
        endcase
    endfunction

    initial begin
        m_pc = 32'h0; m_pend = 1'b0; m_tgt = 32'h0;
        // Reset then free run.
        cyc(1, 0, 0, 0, 0, 0, 0);
        check_eq("reset_pc", bus.pc, 32'h0000_3000);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_eq("free_run_300c", bus.pc, 32'h0000_300C);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Buffered redirect across a two-cycle stall.
        cyc(0, 1, 1, 32'h3100, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        check_eq("stall_hold", bus.pc, 32'h0000_3010);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_eq("pend_apply", bus.pc, 32'h0000_3100);
        // Last buffered wins, then live beats buffered.
        cyc(0, 1, 1, 32'h3100, 0, 0, 0);
        cyc(0, 1, 1, 32'h3200, 0, 0, 0);
        cyc(0, 0, 1, 32'h3300, 0, 0, 0);
        check_eq("live_wins", bus.pc, 32'h0000_3300);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // Exception during stall with pending redirect, then eret.
        cyc(0, 1, 1, 32'h3400, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 0);
        check_eq("exc_vec", bus.pc, 32'h0000_4180);
        cyc(0, 0, 0, 0, 0, 1, 32'h3020);
        check_eq("eret_pc", bus.pc, 32'h0000_3020);
        // Range boundaries.
        cyc(0, 0, 1, 32'h3002, 0, 0, 0);
        cyc(0, 0, 1, 32'h7000, 0, 0, 0);
        cyc(0, 0, 1, 32'h6FFC, 0, 0, 0);
        cyc(0, 0, 1, 32'h2FFC, 0, 0, 0);
        // Reset beats exception with a pending redirect.
        cyc(0, 1, 1, 32'h3500, 0, 0, 0);
        cyc(1, 1, 1, 32'h3600, 1, 1, 32'h3700);
        check_eq("reset_wins", bus.pc, 32'h0000_3000);
        // Wrap at the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_eq("wrap_zero", bus.pc, 32'h0000_0000);
        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 9) < 4),
                ($urandom_range(0, 9) < 3),
                rand_target(),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 29) == 0),
                rand_target());
        end
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
